// File: rtl/cartesian_pair_scheduler.sv
// -----------------------------------------------------------------------------
// cartesian_pair_scheduler
//
// Purpose:
//    Sequences the I x F multiplier array for one convolution layer. It walks
//    every (input-chunk, filter-chunk) pair, with the filter chunk as the inner
//    loop. For each pair it issues an IARAM/weight-buffer read, then presents
//    array_valid until the accumulator buffer accepts the result. It also pulses
//    the decoder restart and layer-change controls once at the start of a layer.
//
// Ports:
//    clk, rst               clock, synchronous active-low reset
//    start, abort           layer start (sampled in IDLE) / synchronous cancel
//    num_in_chunks          N, input chunks in the layer
//    num_flt_chunks         M, filter chunks in the layer
//    in_base, wt_base       IARAM / weight-buffer base chunk addresses
//    acc_ready              accumulator accepts the current array result
//    rd_en                  1-cycle read strobe to IARAM and weight buffer
//    iaram_addr, wt_addr    in_base + ic, wt_base + fc (modulo 2^ADDR_W)
//    decode_restart         1-cycle pulse restarting the input index decoder
//    layer_change_flag      1-cycle pulse resetting filter decoder k tracking
//    array_valid            array/coordinate outputs belong to current pair
//    last_pair              current pair is (N-1, M-1), qualified by array_valid
//    ic, fc                 current input / filter chunk indices
//    busy                   scheduler not idle
//    done                   1-cycle pulse at layer completion
//
// All outputs are registered. They are computed from the next state, so each
// output is aligned with the state it describes.
// -----------------------------------------------------------------------------
module cartesian_pair_scheduler #(
   parameter int ADDR_W = 10,
   parameter int CNT_W  = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [CNT_W-1:0]  num_in_chunks,
   input  logic [CNT_W-1:0]  num_flt_chunks,
   input  logic [ADDR_W-1:0] in_base,
   input  logic [ADDR_W-1:0] wt_base,
   input  logic              acc_ready,
   output logic              rd_en,
   output logic [ADDR_W-1:0] iaram_addr,
   output logic [ADDR_W-1:0] wt_addr,
   output logic              decode_restart,
   output logic              layer_change_flag,
   output logic              array_valid,
   output logic              last_pair,
   output logic [CNT_W-1:0]  ic,
   output logic [CNT_W-1:0]  fc,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_CFG  = 3'd1,
      S_RD   = 3'd2,
      S_WAIT = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_n, r_m, r_ic, r_fc;
   logic [CNT_W-1:0]  w_ic_nxt, w_fc_nxt;
   logic [ADDR_W-1:0] r_in_base, r_wt_base, r_iaram_addr, r_wt_addr;
   logic              r_rd_en, r_decode_restart, r_layer_change, r_array_valid;
   logic              r_last_pair, r_busy, r_done;
   logic              w_latch;
   logic              w_last_cur;
   logic              w_last_nxt;

   // A latched count of zero makes N-1 wrap to all ones. That value is never
   // reached, because a zero-count layer skips straight to DONE.
   assign w_last_cur = (r_ic == r_n - ONE) && (r_fc == r_m - ONE);
   assign w_last_nxt = (w_ic_nxt == r_n - ONE) && (w_fc_nxt == r_m - ONE);

   // Next-state and next-index logic. abort overrides every transition.
   always_comb begin
      w_state_nxt = r_state;
      w_ic_nxt    = r_ic;
      w_fc_nxt    = r_fc;
      w_latch     = 1'b0;
      if (abort) begin
         w_state_nxt = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  w_latch = 1'b1;
                  if ((num_in_chunks != {CNT_W{1'b0}}) && (num_flt_chunks != {CNT_W{1'b0}})) begin
                     w_state_nxt = S_CFG;
                  end else begin
                     w_state_nxt = S_DONE;
                  end
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end
            S_CFG: begin
               w_ic_nxt    = {CNT_W{1'b0}};
               w_fc_nxt    = {CNT_W{1'b0}};
               w_state_nxt = S_RD;
            end
            S_RD: begin
               w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
               if (!acc_ready) begin
                  w_state_nxt = S_WAIT;
               end else if (w_last_cur) begin
                  w_state_nxt = S_DONE;
               end else if (r_fc == r_m - ONE) begin
                  w_fc_nxt    = {CNT_W{1'b0}};
                  w_ic_nxt    = r_ic + ONE;
                  w_state_nxt = S_RD;
               end else begin
                  w_fc_nxt    = r_fc + ONE;
                  w_state_nxt = S_RD;
               end
            end
            S_DONE: begin
               w_state_nxt = S_IDLE;
            end
            default: begin
               w_state_nxt = S_IDLE;
            end
         endcase
      end
   end

   // State, layer configuration, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state          <= S_IDLE;
         r_n              <= {CNT_W{1'b0}};
         r_m              <= {CNT_W{1'b0}};
         r_ic             <= {CNT_W{1'b0}};
         r_fc             <= {CNT_W{1'b0}};
         r_in_base        <= {ADDR_W{1'b0}};
         r_wt_base        <= {ADDR_W{1'b0}};
         r_iaram_addr     <= {ADDR_W{1'b0}};
         r_wt_addr        <= {ADDR_W{1'b0}};
         r_rd_en          <= 1'b0;
         r_decode_restart <= 1'b0;
         r_layer_change   <= 1'b0;
         r_array_valid    <= 1'b0;
         r_last_pair      <= 1'b0;
         r_busy           <= 1'b0;
         r_done           <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ic    <= w_ic_nxt;
         r_fc    <= w_fc_nxt;
         if (w_latch) begin
            r_n       <= num_in_chunks;
            r_m       <= num_flt_chunks;
            r_in_base <= in_base;
            r_wt_base <= wt_base;
         end
         // Addresses change only on entry to RD, so they stay stable through WAIT.
         if (w_state_nxt == S_RD) begin
            r_iaram_addr <= r_in_base + ADDR_W'(w_ic_nxt);
            r_wt_addr    <= r_wt_base + ADDR_W'(w_fc_nxt);
         end
         r_rd_en          <= (w_state_nxt == S_RD);
         r_decode_restart <= (w_state_nxt == S_CFG);
         r_layer_change   <= (w_state_nxt == S_CFG);
         r_array_valid    <= (w_state_nxt == S_WAIT);
         r_last_pair      <= (w_state_nxt == S_WAIT) && w_last_nxt;
         r_busy           <= (w_state_nxt != S_IDLE);
         r_done           <= (w_state_nxt == S_DONE);
      end
   end

   assign rd_en             = r_rd_en;
   assign iaram_addr        = r_iaram_addr;
   assign wt_addr           = r_wt_addr;
   assign decode_restart    = r_decode_restart;
   assign layer_change_flag = r_layer_change;
   assign array_valid       = r_array_valid;
   assign last_pair         = r_last_pair;
   assign ic                = r_ic;
   assign fc                = r_fc;
   assign busy              = r_busy;
   assign done              = r_done;

endmodule
